// File: rtl/thread_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : thread_scheduler_if
// Desc     : Policy/eligibility inputs and registered selection outputs of the
//            thread-issue scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface thread_scheduler_if #(
    parameter int N_THREADS = 8,
    parameter int QUANTUM_W = 4,
    parameter int TID_W     = $clog2(N_THREADS)
);
    logic [1:0]           mode;
    logic [N_THREADS-1:0] stalled;
    logic [N_THREADS-1:0] thread_en;
    logic [QUANTUM_W-1:0] quantum;
    logic [TID_W-1:0]     thread;
    logic                 thread_valid;
    logic                 switched;

    modport master (
        output mode, stalled, thread_en, quantum,
        input  thread, thread_valid, switched
    );

    modport slave (
        input  mode, stalled, thread_en, quantum,
        output thread, thread_valid, switched
    );
endinterface
`default_nettype wire

// File: rtl/thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : thread_scheduler
// Desc     : Per-cycle thread selection with RR, stall-skip RR, quantum RR and
//            fixed-priority policies plus per-thread enable masking.
// Revision : 1.0  initial release
// ============================================================================
module thread_scheduler #(
    parameter int N_THREADS = 8,
    parameter int TID_W     = $clog2(N_THREADS),
    parameter int QUANTUM_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    thread_scheduler_if.slave bus
);

    localparam logic [1:0]       c_MODE_RR    = 2'd0;
    localparam logic [1:0]       c_MODE_SKIP  = 2'd1;
    localparam logic [1:0]       c_MODE_QUANT = 2'd2;
    localparam logic [1:0]       c_MODE_PRIO  = 2'd3;
    localparam logic [TID_W:0]   c_N_EXT      = (TID_W+1)'(N_THREADS);

    logic [TID_W-1:0]     r_thread;
    logic                 r_valid;
    logic                 r_switched;
    logic [QUANTUM_W-1:0] r_qcnt;

    logic [N_THREADS-1:0] w_elig;
    logic [TID_W-1:0]     w_start;
    logic                 w_hit_found;
    logic [TID_W-1:0]     w_hit;
    logic                 w_prio_found;
    logic [TID_W-1:0]     w_prio;
    logic [QUANTUM_W-1:0] w_qlim;
    logic [QUANTUM_W:0]   w_qnext;
    logic                 w_qhold;
    logic [TID_W-1:0]     w_next_thread;
    logic                 w_next_valid;
    logic [QUANTUM_W-1:0] w_next_qcnt;
    logic                 w_next_switched;

    // Reduce a sum of two in-range IDs (< 2*N) back into 0..N-1.
    function automatic logic [TID_W-1:0] f_wrap(input logic [TID_W:0] v);
        if (v >= c_N_EXT)
            return TID_W'(v - c_N_EXT);
        else
            return TID_W'(v);
    endfunction

    assign w_elig  = bus.thread_en & ~bus.stalled;
    assign w_start = r_valid ? f_wrap({1'b0, r_thread} + (TID_W+1)'(1)) : r_thread;

    // Circular search: scanning from the far end lets the entry nearest start win.
    always_comb begin
        logic [TID_W-1:0] v_idx;
        v_idx       = '0;
        w_hit_found = 1'b0;
        w_hit       = w_start;
        for (int k = N_THREADS - 1; k >= 0; k--) begin
            v_idx = f_wrap({1'b0, w_start} + (TID_W+1)'(k));
            if (w_elig[v_idx]) begin
                w_hit_found = 1'b1;
                w_hit       = v_idx;
            end
        end
    end

    always_comb begin
        w_prio_found = 1'b0;
        w_prio       = '0;
        for (int k = N_THREADS - 1; k >= 0; k--) begin
            if (w_elig[k]) begin
                w_prio_found = 1'b1;
                w_prio       = TID_W'(k);
            end
        end
    end

    // A zero quantum behaves as a one-cycle slice; the extra bit keeps qcnt+1 from wrapping.
    assign w_qlim  = (bus.quantum == '0) ? QUANTUM_W'(1) : bus.quantum;
    assign w_qnext = {1'b0, r_qcnt} + (QUANTUM_W+1)'(1);
    assign w_qhold = r_valid & w_elig[r_thread] & (w_qnext < {1'b0, w_qlim});

    always_comb begin
        w_next_thread = r_thread;
        w_next_valid  = 1'b0;
        w_next_qcnt   = '0;
        case (bus.mode)
            c_MODE_RR: begin
                w_next_thread = w_start;
                w_next_valid  = 1'b1;
            end
            c_MODE_SKIP: begin
                if (w_hit_found) begin
                    w_next_thread = w_hit;
                    w_next_valid  = 1'b1;
                end
            end
            c_MODE_QUANT: begin
                if (w_qhold) begin
                    w_next_valid = 1'b1;
                    w_next_qcnt  = w_qnext[QUANTUM_W-1:0];
                end else if (w_hit_found) begin
                    w_next_thread = w_hit;
                    w_next_valid  = 1'b1;
                end
            end
            c_MODE_PRIO: begin
                if (w_prio_found) begin
                    w_next_thread = w_prio;
                    w_next_valid  = 1'b1;
                end
            end
            default: begin
                w_next_thread = r_thread;
                w_next_valid  = 1'b0;
            end
        endcase
        w_next_switched = w_next_valid & (~r_valid | (w_next_thread != r_thread));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thread   <= '0;
            r_valid    <= 1'b0;
            r_switched <= 1'b0;
            r_qcnt     <= '0;
        end else begin
            r_thread   <= w_next_thread;
            r_valid    <= w_next_valid;
            r_switched <= w_next_switched;
            r_qcnt     <= w_next_qcnt;
        end
    end

    assign bus.thread       = r_thread;
    assign bus.thread_valid = r_valid;
    assign bus.switched     = r_switched;

endmodule
`default_nettype wire

// File: tb/tb_thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_thread_scheduler
// Desc     : Scoreboard bench for thread_scheduler with N_THREADS = 8 and 5.
// Revision : 1.0  initial release
// ============================================================================
module tb_thread_scheduler;

    logic clk;
    logic rst8;
    logic rst5;
    int   n_checks = 0;
    int   n_errors = 0;

    // Entry layout: {thread[2:0], thread_valid, switched}
    logic [4:0] q8[$];
    logic [4:0] q5[$];

    thread_scheduler_if #(.N_THREADS(8), .QUANTUM_W(4)) if8 ();
    thread_scheduler_if #(.N_THREADS(5), .QUANTUM_W(4)) if5 ();

    thread_scheduler #(.N_THREADS(8), .QUANTUM_W(4)) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (if8.slave)
    );

    thread_scheduler #(.N_THREADS(5), .QUANTUM_W(4)) dut5 (
        .clk (clk),
        .rst (rst5),
        .bus (if5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got thread=%0d valid=%0b switched=%0b, expected thread=%0d valid=%0b switched=%0b",
                     name, act[4:2], act[1], act[0], exp[4:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [4:0] cur8();
        return {if8.thread, if8.thread_valid, if8.switched};
    endfunction

    function automatic logic [4:0] cur5();
        return {if5.thread, if5.thread_valid, if5.switched};
    endfunction

    task automatic step8(input logic [2:0] t, input logic v, input logic s);
        q8.push_back({t, v, s});
        @(posedge clk);
        #2;
    endtask

    task automatic step5(input logic [2:0] t, input logic v, input logic s);
        q5.push_back({t, v, s});
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (q8.size() > 0) check("dut8", cur8(), q8.pop_front());
        if (q5.size() > 0) check("dut5", cur5(), q5.pop_front());
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst8 = 1'b1;
        rst5 = 1'b1;
        if8.mode = 2'd0; if8.stalled = 8'h00; if8.thread_en = 8'hFF; if8.quantum = 4'd0;
        if5.mode = 2'd1; if5.stalled = 5'b00000; if5.thread_en = 5'b10001; if5.quantum = 4'd0;
        @(posedge clk);
        #2;
        check("reset8", cur8(), 5'b000_0_0);
        check("reset5", cur5(), 5'b000_0_0);
        rst8 = 1'b0;

        // RR: 0..7 then wrap to 0, switching every cycle
        for (int i = 0; i < 9; i++) step8(3'(i % 8), 1'b1, 1'b1);

        // SKIP around stalled threads 1 and 2
        if8.mode = 2'd1; if8.stalled = 8'b0000_0110;
        step8(3'd3, 1'b1, 1'b1);
        step8(3'd4, 1'b1, 1'b1);
        // everything stalled: hold last ID, invalid
        if8.stalled = 8'hFF;
        step8(3'd4, 1'b0, 1'b0);
        step8(3'd4, 1'b0, 1'b0);
        // release only thread 5; reselecting it does not switch
        if8.stalled = 8'b1101_1111;
        step8(3'd5, 1'b1, 1'b1);
        step8(3'd5, 1'b1, 1'b0);

        // QUANTUM=3 starting mid-run on thread 5 with qcnt cleared
        if8.mode = 2'd2; if8.stalled = 8'h00; if8.quantum = 4'd3;
        step8(3'd5, 1'b1, 1'b0);
        step8(3'd5, 1'b1, 1'b0);
        step8(3'd6, 1'b1, 1'b1);
        step8(3'd6, 1'b1, 1'b0);
        step8(3'd6, 1'b1, 1'b0);
        step8(3'd7, 1'b1, 1'b1);
        step8(3'd7, 1'b1, 1'b0);
        step8(3'd7, 1'b1, 1'b0);
        step8(3'd0, 1'b1, 1'b1);
        step8(3'd0, 1'b1, 1'b0);
        step8(3'd0, 1'b1, 1'b0);
        step8(3'd1, 1'b1, 1'b1);
        step8(3'd1, 1'b1, 1'b0);
        // stall thread 1 during its second cycle: preempted, thread 2 gets a full slice
        if8.stalled = 8'b0000_0010;
        step8(3'd2, 1'b1, 1'b1);
        if8.stalled = 8'h00;
        step8(3'd2, 1'b1, 1'b0);
        step8(3'd2, 1'b1, 1'b0);
        step8(3'd3, 1'b1, 1'b1);
        // quantum 0 acts as 1
        if8.quantum = 4'd0;
        step8(3'd4, 1'b1, 1'b1);
        step8(3'd5, 1'b1, 1'b1);

        // PRIO
        if8.mode = 2'd3; if8.stalled = 8'b0000_0011; if8.thread_en = 8'hFE;
        step8(3'd2, 1'b1, 1'b1);
        step8(3'd2, 1'b1, 1'b0);
        step8(3'd2, 1'b1, 1'b0);
        if8.thread_en = 8'h00;
        step8(3'd2, 1'b0, 1'b0);
        if8.thread_en = 8'hFE; if8.stalled = 8'h00;
        step8(3'd1, 1'b1, 1'b1);
        // immediate switch back to RR
        if8.mode = 2'd0;
        step8(3'd2, 1'b1, 1'b1);

        // N=5, SKIP with only threads 0 and 4 enabled
        rst5 = 1'b0;
        step5(3'd0, 1'b1, 1'b1);
        step5(3'd4, 1'b1, 1'b1);
        step5(3'd0, 1'b1, 1'b1);
        step5(3'd4, 1'b1, 1'b1);
        // asynchronous reset mid-cycle, observed before the next edge
        #1;
        rst5 = 1'b1;
        #1;
        check("async_rst5", cur5(), 5'b000_0_0);
        @(posedge clk);
        #2;
        rst5 = 1'b0;
        step5(3'd0, 1'b1, 1'b1);
        step5(3'd4, 1'b1, 1'b1);
        // RR wrap on a non-power-of-two count
        if5.mode = 2'd0;
        step5(3'd0, 1'b1, 1'b1);
        step5(3'd1, 1'b1, 1'b1);
        step5(3'd2, 1'b1, 1'b1);
        step5(3'd3, 1'b1, 1'b1);
        step5(3'd4, 1'b1, 1'b1);
        step5(3'd0, 1'b1, 1'b1);

        @(posedge clk);
        #3;
        n_checks++;
        if (q8.size() != 0 || q5.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", q8.size(), q5.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
